// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD-card read-port arbiter and its helpers.
package sd_arb_pkg;

   localparam int SECTOR_BYTES = 512;
   localparam int ADDR_W       = $clog2(SECTOR_BYTES);
   localparam int DEF_NREQ     = 3;
   localparam int DEF_LBA_W    = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      XFER
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after index rr, wrapping modulo N.
module rr_pick #(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] rr,
   output logic [N-1:0]     pick,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   int             off;

   // Rotate the doubled vector so bit 0 is the requester just after rr.
   always_comb begin
      dbl   = {req, req};
      rot   = N'(dbl >> (int'(rr) + 1));
      valid = |req;
      off   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) off = k;
      end
      idx  = IDX_W'((int'(rr) + 1 + off) % N);
      pick = valid ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/sd_read_arbiter.sv
// Round-robin arbiter sharing one SD sector-read port between NREQ requesters.
// Define SD_ARB_TIMEOUT_EN to add a watchdog with a sticky timeout_err output.
module sd_read_arbiter
   import sd_arb_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int LBA_W = DEF_LBA_W
`ifdef SD_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 1048575
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_rd,
   input  logic [NREQ*LBA_W-1:0] req_lba,
   output logic [NREQ-1:0]       req_busy,
   output logic [NREQ-1:0]       req_done,
   output logic [NREQ-1:0]       req_data_en,
   output logic [ADDR_W-1:0]     req_addr,
   output logic [7:0]            req_data,
   output logic [LBA_W-1:0]      sd_lba,
   output logic [NREQ-1:0]       sd_rd,
   input  logic                  sd_busy,
   input  logic                  sd_done,
   input  logic [ADDR_W-1:0]     sd_addr,
   input  logic                  sd_data_en,
   input  logic [7:0]            sd_data,
`ifdef SD_ARB_TIMEOUT_EN
   output logic                  timeout_err,
`endif
   output logic [NREQ-1:0]       grant
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_t       state;
   logic [IDX_W-1:0] rr;
   logic [IDX_W-1:0] owner;
   logic             sd_busy_q;
   logic [NREQ-1:0]  pick_onehot;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_valid;

   rr_pick #(.N(NREQ), .IDX_W(IDX_W)) u_pick (
      .req   (req_rd),
      .rr    (rr),
      .pick  (pick_onehot),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   assign req_addr    = sd_addr;
   assign req_data    = sd_data;
   assign req_data_en = {NREQ{sd_data_en}} & grant;

   // Non-owners see busy while a transaction is in flight or pending, so they hold off.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_busy[i] = (grant[i] || (state == IDLE && !(|req_rd))) ? sd_busy : 1'b1;
      end
   end

`ifdef SD_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wd_cnt;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sd_rd     <= '0;
         sd_lba    <= '0;
         grant     <= '0;
         req_done  <= '0;
         rr        <= '0;
         owner     <= '0;
         sd_busy_q <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         sd_busy_q <= sd_busy;
         req_done  <= '0;
         case (state)
            IDLE: begin
               if (!sd_busy && pick_valid) begin
                  grant  <= pick_onehot;
                  sd_rd  <= pick_onehot;
                  sd_lba <= req_lba[pick_idx*LBA_W +: LBA_W];
                  owner  <= pick_idx;
                  state  <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (sd_busy) begin
                  sd_rd <= '0;
                  state <= XFER;
               end else if (!req_rd[owner]) begin
                  sd_rd <= '0;
                  grant <= '0;
                  state <= IDLE;
               end
            end
            XFER: begin
               // Either an explicit done pulse or busy falling ends the sector.
               if (sd_done || (sd_busy_q && !sd_busy)) begin
                  req_done <= grant;
                  rr       <= owner;
                  grant    <= '0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
`ifdef SD_ARB_TIMEOUT_EN
         if (state == IDLE || (state == WAIT_BUSY && sd_busy)) begin
            wd_cnt <= '0;
         end else begin
            wd_cnt <= wd_cnt + 1'b1;
         end
         // Watchdog overrides the normal transitions above.
         if (state != IDLE && wd_cnt == CNT_W'(TIMEOUT - 1)) begin
            sd_rd       <= '0;
            req_done    <= grant;
            grant       <= '0;
            rr          <= owner;
            timeout_err <= 1'b1;
            wd_cnt      <= '0;
            state       <= IDLE;
         end
`endif
      end
   end

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Scoreboard bench for sd_read_arbiter: expected grants are queued at stimulus time and popped on sd_rd.
module tb_sd_read_arbiter;
   import sd_arb_pkg::*;

   localparam int NREQ  = 3;
   localparam int LBA_W = 32;

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req_rd;
   logic [NREQ*LBA_W-1:0] req_lba;
   logic [NREQ-1:0]       req_busy;
   logic [NREQ-1:0]       req_done;
   logic [NREQ-1:0]       req_data_en;
   logic [ADDR_W-1:0]     req_addr;
   logic [7:0]            req_data;
   logic [LBA_W-1:0]      sd_lba;
   logic [NREQ-1:0]       sd_rd;
   logic                  sd_busy;
   logic                  sd_done;
   logic [ADDR_W-1:0]     sd_addr;
   logic                  sd_data_en;
   logic [7:0]            sd_data;
   logic [NREQ-1:0]       grant;
`ifdef SD_ARB_TIMEOUT_EN
   logic                  timeout_err;
`endif

   sd_read_arbiter #(
      .NREQ  (NREQ),
      .LBA_W (LBA_W)
`ifdef SD_ARB_TIMEOUT_EN
      ,
      .TIMEOUT (50)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_rd      (req_rd),
      .req_lba     (req_lba),
      .req_busy    (req_busy),
      .req_done    (req_done),
      .req_data_en (req_data_en),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .sd_lba      (sd_lba),
      .sd_rd       (sd_rd),
      .sd_busy     (sd_busy),
      .sd_done     (sd_done),
      .sd_addr     (sd_addr),
      .sd_data_en  (sd_data_en),
      .sd_data     (sd_data),
`ifdef SD_ARB_TIMEOUT_EN
      .timeout_err (timeout_err),
`endif
      .grant       (grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int               idx;
      logic [LBA_W-1:0] lba;
   } grant_t;

   grant_t           expQ[$];
   logic [LBA_W-1:0] lbaVal[NREQ];
   int               checks   = 0;
   int               failures = 0;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, wanted %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] rd);
      for (int i = 0; i < NREQ; i++) req_lba[i*LBA_W +: LBA_W] = lbaVal[i];
      req_rd = rd;
   endtask

   function automatic void expectGrant(input int idx);
      grant_t g;
      g.idx = idx;
      g.lba = lbaVal[idx];
      expQ.push_back(g);
   endfunction

   task automatic awaitGrant(input int expLatency, output grant_t e, output bit ok);
      int waited;
      logic [NREQ-1:0] others;
      waited = 0;
      ok     = 1'b0;
      e.idx  = 0;
      e.lba  = '0;
      do begin
         tick();
         waited++;
      end while (sd_rd == '0 && waited < 50);
      if (sd_rd == '0) begin
         checkOutput("grant_wait", 64'd0, 64'd1);
         return;
      end
      if (expQ.size() == 0) begin
         checkOutput("sb_underflow", 64'd0, 64'd1);
         return;
      end
      e  = expQ.pop_front();
      ok = 1'b1;
      if (expLatency > 0) checkOutput("grant_latency", 64'(waited), 64'(expLatency));
      others = ~(NREQ'(1) << e.idx);
      checkOutput($sformatf("sd_rd_r%0d", e.idx), 64'(sd_rd), 64'(1) << e.idx);
      checkOutput($sformatf("sd_lba_r%0d", e.idx), 64'(sd_lba), 64'(e.lba));
      checkOutput($sformatf("grant_r%0d", e.idx), 64'(grant), 64'(1) << e.idx);
      checkOutput("busy_others", 64'(req_busy & others), 64'(others));
   endtask

   // Host model: raise busy after busyDelay clocks, stream a sector, pulse done; optional reset at byte resetAt.
   task automatic serveSector(input int busyDelay, input int expLatency, input int resetAt,
                              input logic [NREQ-1:0] rdAfterBusy);
      grant_t e;
      bit     ok;
      int     cnt[NREQ];
      int     dataErr;
      int     doneErr;
      logic [7:0] b;
      logic [NREQ-1:0] others;
      dataErr = 0;
      doneErr = 0;
      for (int i = 0; i < NREQ; i++) cnt[i] = 0;
      awaitGrant(expLatency, e, ok);
      if (!ok) return;
      others = ~(NREQ'(1) << e.idx);
      lbaVal[e.idx] = e.lba ^ 32'hDEAD_BEEF;
      applyStimulus(req_rd);
      repeat (busyDelay - 1) tick();
      checkOutput("lba_latched", 64'(sd_lba), 64'(e.lba));
      checkOutput("sd_rd_hold", 64'(sd_rd), 64'(1) << e.idx);
      lbaVal[e.idx] = e.lba;
      applyStimulus(req_rd);
      tick();
      sd_busy = 1'b1;
      tick();
      checkOutput("sd_rd_clear", 64'(sd_rd), 64'd0);
      req_rd = rdAfterBusy;
      for (int k = 0; k < SECTOR_BYTES; k++) begin
         if (k == resetAt) begin
            sd_data_en = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            checkOutput("rst_sd_rd", 64'(sd_rd), 64'd0);
            checkOutput("rst_grant", 64'(grant), 64'd0);
            checkOutput("rst_sd_lba", 64'(sd_lba), 64'd0);
            checkOutput("rst_req_done", 64'(req_done), 64'd0);
         end
         b = 8'(k) ^ e.lba[7:0];
         sd_data_en = 1'b1;
         sd_addr    = ADDR_W'(k);
         sd_data    = b;
         tick();
         for (int i = 0; i < NREQ; i++) if (req_data_en[i]) cnt[i]++;
         if (req_data_en[e.idx] && (req_data !== b || req_addr !== ADDR_W'(k))) dataErr++;
         if (req_done != '0) doneErr++;
         if ((req_busy & others) != others) doneErr++;
      end
      sd_data_en = 1'b0;
      if (resetAt < 0) begin
         sd_done = 1'b1;
         tick();
         checkOutput("req_done_pulse", 64'(req_done), 64'(1) << e.idx);
         checkOutput("grant_release", 64'(grant), 64'd0);
         sd_done = 1'b0;
         sd_busy = 1'b0;
         tick();
         checkOutput("req_done_width", 64'(req_done), 64'd0);
      end else begin
         sd_busy = 1'b0;
         tick();
         checkOutput("no_done_after_rst", 64'(req_done), 64'd0);
      end
      for (int i = 0; i < NREQ; i++) begin
         checkOutput($sformatf("bytes_r%0d_own%0d", i, e.idx), 64'(cnt[i]),
                     (i == e.idx) ? 64'((resetAt < 0) ? SECTOR_BYTES : resetAt) : 64'd0);
      end
      checkOutput("data_stream", 64'(dataErr), 64'd0);
      checkOutput("xfer_done_busy", 64'(doneErr), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL global_watchdog: simulation did not finish");
      $fatal(1, "[TB] global watchdog expired");
   end

   initial begin
      grant_t e;
      bit     ok;
      int     n;
      rst        = 1'b1;
      req_rd     = '0;
      req_lba    = '0;
      sd_busy    = 1'b0;
      sd_done    = 1'b0;
      sd_addr    = '0;
      sd_data_en = 1'b0;
      sd_data    = '0;
      for (int i = 0; i < NREQ; i++) lbaVal[i] = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      checkOutput("reset_sd_rd", 64'(sd_rd), 64'd0);
      checkOutput("reset_sd_lba", 64'(sd_lba), 64'd0);
      checkOutput("reset_grant", 64'(grant), 64'd0);
      checkOutput("reset_req_done", 64'(req_done), 64'd0);
      checkOutput("reset_data_en", 64'(req_data_en), 64'd0);
      checkOutput("reset_req_busy", 64'(req_busy), 64'd0);

`ifdef SD_ARB_TIMEOUT_EN
      lbaVal[0] = 32'd5;
      applyStimulus(3'b001);
      expectGrant(0);
      awaitGrant(1, e, ok);
      n = 0;
      while (sd_rd != '0 && n < 200) begin
         n++;
         tick();
      end
      checkOutput("timeout_cycles", 64'(n), 64'd50);
      checkOutput("timeout_done", 64'(req_done), 64'b001);
      checkOutput("timeout_err_set", 64'(timeout_err), 64'd1);
      checkOutput("timeout_grant", 64'(grant), 64'd0);
      req_rd = '0;
      repeat (5) tick();
      checkOutput("timeout_err_sticky", 64'(timeout_err), 64'd1);
      checkOutput("timeout_done_width", 64'(req_done), 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("timeout_err_clear", 64'(timeout_err), 64'd0);
`else
      // Single request from requester 0.
      lbaVal[0] = 32'd100;
      applyStimulus(3'b001);
      expectGrant(0);
      serveSector(3, 1, -1, 3'b000);

      // Contention: with rr starting at 0 the rotation is 1, 2, 0, 1.
      lbaVal[0] = 32'd10;
      lbaVal[1] = 32'd20;
      lbaVal[2] = 32'd30;
      applyStimulus(3'b111);
      expectGrant(1);
      expectGrant(2);
      expectGrant(0);
      expectGrant(1);
      serveSector(2, 1, -1, 3'b111);
      serveSector(2, -1, -1, 3'b111);
      serveSector(2, -1, -1, 3'b111);
      serveSector(2, -1, -1, 3'b000);

      // Reset in the middle of a transfer.
      lbaVal[0] = 32'd55;
      applyStimulus(3'b001);
      expectGrant(0);
      serveSector(2, 1, 200, 3'b000);

      // Cancel before busy; rr must still be 0 afterwards.
      lbaVal[1] = 32'd77;
      applyStimulus(3'b010);
      expectGrant(1);
      awaitGrant(1, e, ok);
      req_rd = '0;
      tick();
      checkOutput("cancel_sd_rd", 64'(sd_rd), 64'd0);
      checkOutput("cancel_grant", 64'(grant), 64'd0);
      lbaVal[2] = 32'd88;
      applyStimulus(3'b110);
      expectGrant(1);
      serveSector(1, 1, -1, 3'b000);
`endif

      tick();
      checkOutput("sb_drained", 64'(expQ.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/sd_read_arbiter.md
Name: sd_read_arbiter

Overview:
- Shares the single SD-card block-read port (LBA, per-slot read strobe, busy/done, byte stream) between NREQ sector requesters.
- Requesters are the internal floppy track loader, the external floppy track loader and the SCSI disk.
- Grants whole 512-byte sector transactions round-robin and routes busy, data and done back only to the granted requester.
- Sits between the requesters and the SD host interface block; requesters keep their existing level-until-busy read protocol unchanged.

Parameters:
- NREQ, 3, number of requesters; requester i maps to SD image slot i.
- LBA_W, 32, LBA width per requester and on the host side.
- TIMEOUT, 1048575, watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_rd  in  NREQ  per-requester read request; level, held until that requester sees its req_busy high
- req_lba  in  NREQ*LBA_W  per-requester LBA; slice i is bits [i*LBA_W +: LBA_W]
- req_busy  out  NREQ  per-requester busy view
- req_done  out  NREQ  one-cycle sector-complete pulse to the granted requester
- req_data_en  out  NREQ  byte strobe to the granted requester only
- req_addr  out  9  byte index within the sector, broadcast to all requesters
- req_data  out  8  data byte, broadcast to all requesters
- sd_lba  out  LBA_W  LBA to SD host
- sd_rd  out  NREQ  one-hot read strobe to SD host (bit = image slot)
- sd_busy  in  1  SD host busy
- sd_done  in  1  SD host sector-done pulse
- sd_addr  in  9  SD host byte index
- sd_data_en  in  1  SD host byte strobe
- sd_data  in  8  SD host data byte
- grant  out  NREQ  one-hot current owner; 0 when idle (debug)

Behaviour:
- Reset values:
  - State IDLE.
  - sd_rd=0, sd_lba=0, grant=0, req_done=0, req_data_en=0.
  - Round-robin pointer rr=0; rr is the index of the last-served requester.
- req_busy, combinational:
  - Granted requester: sd_busy.
  - All other requesters: 1 whenever state!=IDLE or any req_rd is pending (blocks them from issuing); otherwise sd_busy.
- req_addr=sd_addr and req_data=sd_data, unregistered.
- req_data_en[i] = sd_data_en & grant[i]. Bytes arriving while no requester is granted are dropped.
- IDLE:
  - If sd_busy=0 and any req_rd is set, pick the first set requester searching rr+1, rr+2, ... (modulo NREQ).
  - Register grant, sd_lba=req_lba[sel] and sd_rd=one-hot(sel); go to WAIT_BUSY.
  - Decision to registered outputs takes 1 clk.
- WAIT_BUSY:
  - Hold sd_rd and sd_lba.
  - On sd_busy=1: clear sd_rd and go to XFER.
  - If the granted req_rd drops before busy (cancel): clear sd_rd and grant, return to IDLE; rr is unchanged.
- XFER:
  - Stream bytes to the owner.
  - On sd_done=1 or a 1->0 transition of sd_busy: pulse req_done[owner] for 1 clk, set rr=owner, clear grant, go to IDLE.
- LBA is latched at grant; later changes to req_lba do not affect the transaction in flight.
- Simultaneous requests: strict rotation. With all NREQ requesting continuously, each requester is served once per NREQ transactions. No requester waits more than NREQ-1 transactions.
- A new grant is never issued in the same cycle a transaction ends; there is a minimum 1 clk IDLE gap.
- rst mid-transaction: drops to IDLE immediately and sd_rd clears. Any SD bytes still arriving are dropped because grant=0.
- NREQ=1 degenerates to a pass-through with one cycle of grant latency.

Optional Feature:
- Macro: SD_ARB_TIMEOUT_EN.
- Enabled:
  - A counter runs in WAIT_BUSY and XFER and clears on each state entry.
  - When it reaches TIMEOUT: clear sd_rd, pulse req_done[owner], set a sticky output timeout_err (1 bit, cleared by rst), set rr=owner and go to IDLE.
  - The timeout_err port exists only when the macro is defined.
- Disabled: no counter; the arbiter waits indefinitely.

Decomposition:
- Shared package sd_arb_pkg holds:
  - State enum (IDLE, WAIT_BUSY, XFER).
  - SECTOR_BYTES=512.
  - Default NREQ/LBA_W.
- Natural sub-module: rr_pick, a combinational round-robin priority selector (inputs: request vector and rr; outputs: one-hot pick and index). It is reusable for other shared SD or RAM ports.

Test Plan:
- Single request: req_rd=3'b001, lba0=100; host raises busy after 3 clk, streams 512 bytes, pulses done. Required: sd_rd=001 and sd_lba=100 one clk after the request; req_data_en[0] fires 512 times; req_done[0] pulses once; grant returns to 0.
- Contention: req_rd=3'b111 held, lbas 10/20/30. Required: served in order 1, 2, 0, 1 (rr starts at 0); each sd_lba matches its requester; req_busy=1 for non-owners throughout.
- Isolation: during a transaction owned by 2, req_data_en[0] and req_data_en[1] stay 0 for all 512 bytes.
- Cancel: requester 1 drops req_rd in WAIT_BUSY before sd_busy rises. Required: sd_rd clears next clk; return to IDLE; rr is still 0, so the next simultaneous 1+2 request grants 1.
- Reset mid-XFER at byte 200: rst for 1 clk. Required: all outputs at reset values the next clk; the remaining bytes produce no req_data_en.
- With SD_ARB_TIMEOUT_EN and TIMEOUT=50: sd_busy never rises. Required: at cycle 50 sd_rd clears, req_done[owner] pulses, timeout_err=1 and stays set until rst.
